// File: rtl/pwm_carrier_compare_tdm_pkg.sv
// Shared constants for the time-multiplexed PWM carrier comparator.
//   N_WINDTURBINE : default number of converter channels swept per step
//   CARRIER_W     : default signed width of references and carrier
//   CMAX_DEF      : default carrier peak, carrier spans [-CMAX, +CMAX]
//   CSTEP_DEF     : default carrier increment per time step
//   state_t       : sweep FSM state encoding
package pwm_carrier_compare_tdm_pkg;

  localparam int N_WINDTURBINE = 4;
  localparam int CARRIER_W     = 18;
  localparam int CMAX_DEF      = 1000;
  localparam int CSTEP_DEF     = 300;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CMP  = 2'd2,
    ST_UPD  = 2'd3
  } state_t;

endpackage

// File: rtl/pwm_carrier_compare_tdm_tri_carrier_gen.sv
// Triangular carrier generator: saturating up/down ramp between -CMAX and
// +CMAX, moving by CSTEP once per advance pulse.
//   clk       : system clock
//   rst       : asynchronous active-high reset (carrier=0, direction=up)
//   advance_i : one-cycle request to move the carrier one step
//   carrier_o : current carrier value (registered, signed)
import pwm_carrier_compare_tdm_pkg::*;

module tri_carrier_gen #(
  parameter int W     = CARRIER_W,
  parameter int CMAX  = CMAX_DEF,
  parameter int CSTEP = CSTEP_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                advance_i,
  output logic signed [W-1:0] carrier_o
);

  // One extra bit of headroom so the step never wraps before the clamp.
  localparam logic signed [W:0] CMAX_X  = (W+1)'(CMAX);
  localparam logic signed [W:0] CMIN_X  = -CMAX_X;
  localparam logic signed [W:0] CSTEP_X = (W+1)'(CSTEP);

  logic signed [W-1:0] carrier_q, carrier_d;
  logic                down_q, down_d;
  logic signed [W:0]   car_x, up_x, dn_x;

  always_comb begin
    car_x     = {carrier_q[W-1], carrier_q};
    up_x      = car_x + CSTEP_X;
    dn_x      = car_x - CSTEP_X;
    carrier_d = carrier_q;
    down_d    = down_q;
    if (advance_i) begin
      if (!down_q) begin
        if (up_x >= CMAX_X) begin
          carrier_d = CMAX_X[W-1:0];
          down_d    = 1'b1;
        end else begin
          carrier_d = up_x[W-1:0];
        end
      end else begin
        if (dn_x <= CMIN_X) begin
          carrier_d = CMIN_X[W-1:0];
          down_d    = 1'b0;
        end else begin
          carrier_d = dn_x[W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carrier_q <= '0;
      down_q    <= 1'b0;
    end else begin
      carrier_q <= carrier_d;
      down_q    <= down_d;
    end
  end

  assign carrier_o = carrier_q;

endmodule

// File: rtl/pwm_carrier_compare_tdm.sv
// Time-multiplexed carrier-comparison PWM modulator. Each start strobe sweeps
// channels 0..N-1: fetch the channel reference, compare it against the shared
// triangular carrier, emit one gate bit with a write strobe. After the last
// channel the carrier advances one step and step_done pulses.
//   clk, rst        : system clock, asynchronous active-high reset
//   start_i         : one-cycle time-step strobe
//   ref_req_o       : reference requested for ref_idx_o
//   ref_idx_o       : channel being requested/compared
//   ref_valid_i     : ref_data_i valid (honoured only while ref_req_o=1)
//   ref_data_i      : signed modulation reference
//   pwm_bit_o       : gate result of the channel just compared
//   pwm_wr_o        : one-cycle strobe qualifying pwm_bit_o
//   step_done_o     : one-cycle pulse after the carrier update
//   busy_o          : sweep in progress
//   carrier_o       : current carrier value
//   overrun_o       : sticky, start seen while busy
//
// state   | meaning
// ST_IDLE | waiting for start
// ST_REQ  | ref_req high, waiting for ref_valid on ref_idx
// ST_CMP  | captured reference compared against carrier
// ST_UPD  | carrier advance, sweep ends
import pwm_carrier_compare_tdm_pkg::*;

module pwm_carrier_compare_tdm #(
  parameter int N     = N_WINDTURBINE,
  parameter int W     = CARRIER_W,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1,
  parameter int CMAX  = CMAX_DEF,
  parameter int CSTEP = CSTEP_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  output logic                ref_req_o,
  output logic [IDX_W-1:0]    ref_idx_o,
  input  logic                ref_valid_i,
  input  logic signed [W-1:0] ref_data_i,
  output logic                pwm_bit_o,
  output logic                pwm_wr_o,
  output logic                step_done_o,
  output logic                busy_o,
  output logic signed [W-1:0] carrier_o,
  output logic                overrun_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t              state_q;
  logic                ref_req_q;
  logic [IDX_W-1:0]    idx_q;
  logic signed [W-1:0] ref_cap_q;
  logic                pwm_bit_q;
  logic                pwm_wr_q;
  logic                step_done_q;
  logic                busy_q;
  logic                overrun_q;
  logic signed [W-1:0] carrier_w;

  // Carrier moves on the UPD cycle only, so every channel of a sweep sees
  // the same value.
  tri_carrier_gen #(
    .W     (W),
    .CMAX  (CMAX),
    .CSTEP (CSTEP)
  ) u_carrier (
    .clk       (clk),
    .rst       (rst),
    .advance_i (state_q == ST_UPD),
    .carrier_o (carrier_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ref_req_q   <= 1'b0;
      idx_q       <= '0;
      ref_cap_q   <= '0;
      pwm_bit_q   <= 1'b0;
      pwm_wr_q    <= 1'b0;
      step_done_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      pwm_wr_q    <= 1'b0;
      step_done_q <= 1'b0;
      // busy is still high on the UPD cycle, so a start there is an overrun.
      if (start_i && busy_q) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q   <= ST_REQ;
            idx_q     <= '0;
            ref_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_REQ: begin
          if (ref_valid_i) begin
            ref_cap_q <= ref_data_i;
            ref_req_q <= 1'b0;
            state_q   <= ST_CMP;
          end
        end
        ST_CMP: begin
          pwm_bit_q <= (ref_cap_q > carrier_w);
          pwm_wr_q  <= 1'b1;
          if (idx_q == LAST_IDX) begin
            state_q <= ST_UPD;
          end else begin
            idx_q     <= idx_q + IDX_W'(1);
            ref_req_q <= 1'b1;
            state_q   <= ST_REQ;
          end
        end
        ST_UPD: begin
          step_done_q <= 1'b1;
          busy_q      <= 1'b0;
          idx_q       <= '0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ref_req_o   = ref_req_q;
  assign ref_idx_o   = idx_q;
  assign pwm_bit_o   = pwm_bit_q;
  assign pwm_wr_o    = pwm_wr_q;
  assign step_done_o = step_done_q;
  assign busy_o      = busy_q;
  assign carrier_o   = carrier_w;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_pwm_carrier_compare_tdm.sv
// Bench for pwm_carrier_compare_tdm: a table of hand-computed steps, hand
// sequences for overrun and mid-sweep reset, then random steps checked
// against an integer carrier/compare model.
module tb_pwm_carrier_compare_tdm;

  localparam int NCH   = 4;
  localparam int W     = 18;
  localparam int CMAX  = 1000;
  localparam int CSTEP = 300;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start_i = 1'b0;
  logic                ref_valid_i = 1'b0;
  logic signed [W-1:0] ref_data_i = '0;
  logic                ref_req_o, pwm_bit_o, pwm_wr_o, step_done_o, busy_o, overrun_o;
  logic [1:0]          ref_idx_o;
  logic signed [W-1:0] carrier_o;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int car_m = 0;
  bit dn_m  = 1'b0;

  // current step stimulus / expectations
  int refs  [NCH];
  int dly   [NCH];
  int exp_b [NCH];
  int exp_pre, exp_post;

  typedef struct {
    int                           car_before;
    logic [NCH-1:0][W-1:0]        r;
    logic [NCH-1:0][2:0]          d;
    logic [NCH-1:0]               b;
    int                           car_after;
  } vec_t;

  vec_t tbl [13];

  pwm_carrier_compare_tdm #(
    .N     (NCH),
    .W     (W),
    .CMAX  (CMAX),
    .CSTEP (CSTEP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .ref_req_o   (ref_req_o),
    .ref_idx_o   (ref_idx_o),
    .ref_valid_i (ref_valid_i),
    .ref_data_i  (ref_data_i),
    .pwm_bit_o   (pwm_bit_o),
    .pwm_wr_o    (pwm_wr_o),
    .step_done_o (step_done_o),
    .busy_o      (busy_o),
    .carrier_o   (carrier_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int cb, int r0, int r1, int r2, int r3,
                              int d0, int d1, int d2, int d3,
                              int b0, int b1, int b2, int b3, int ca);
    vec_t v;
    v.car_before = cb;
    v.r[0] = W'(r0); v.r[1] = W'(r1); v.r[2] = W'(r2); v.r[3] = W'(r3);
    v.d[0] = 3'(d0); v.d[1] = 3'(d1); v.d[2] = 3'(d2); v.d[3] = 3'(d3);
    v.b[0] = 1'(b0); v.b[1] = 1'(b1); v.b[2] = 1'(b2); v.b[3] = 1'(b3);
    v.car_after = ca;
    return v;
  endfunction

  // Triangle carrier: climb by CSTEP, clamp at the peaks and turn around.
  function automatic void model_adv();
    if (!dn_m) begin
      if (car_m + CSTEP >= CMAX) begin car_m = CMAX; dn_m = 1'b1; end
      else car_m = car_m + CSTEP;
    end else begin
      if (car_m - CSTEP <= -CMAX) begin car_m = -CMAX; dn_m = 1'b0; end
      else car_m = car_m - CSTEP;
    end
  endfunction

  task automatic prepare_random();
    int r;
    exp_pre = car_m;
    for (int k = 0; k < NCH; k++) begin
      if ($urandom_range(0, 2) == 0) r = car_m + int'($urandom_range(0, 2)) - 1;
      else r = int'($urandom_range(0, 262143)) - 131072;
      refs[k]  = r;
      dly[k]   = ($urandom_range(0, 7) == 0) ? 6 : int'($urandom_range(0, 2));
      exp_b[k] = (r > car_m) ? 1 : 0;
    end
    model_adv();
    exp_post = car_m;
  endtask

  // Called at a negedge; start goes high immediately. ovr_mode: 0 none,
  // 1 extra start mid-sweep, 2 extra start on the carrier-update cycle.
  task automatic run_step(input int ovr_mode);
    int exp_idx, req_cnt, nwr, cyc;
    bit prev_wr, done;
    int got [NCH];
    exp_idx = 0; req_cnt = 0; nwr = 0; cyc = 0; prev_wr = 1'b0; done = 1'b0;
    for (int k = 0; k < NCH; k++) got[k] = -1;
    start_i = 1'b1;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start_i     = 1'b0;
      ref_valid_i = 1'b0;
      if (ovr_mode == 1 && cyc == 3) start_i = 1'b1;
      if (pwm_wr_o) begin
        chk("pwm_wr_spacing", int'(prev_wr), 0);
        if (nwr < NCH) got[nwr] = int'(pwm_bit_o);
        nwr++;
        if (ovr_mode == 2 && nwr == NCH) start_i = 1'b1;
      end
      if (step_done_o) begin
        done = 1'b1;
        chk("done_after_last_wr", int'(prev_wr), 1);
        chk("wr_count", nwr, NCH);
        chk("carrier_post", int'(carrier_o), exp_post);
        chk("busy_at_done", int'(busy_o), 0);
        chk("idx_at_done", int'(ref_idx_o), 0);
      end else begin
        chk("carrier_hold", int'(carrier_o), exp_pre);
        chk("busy", int'(busy_o), 1);
      end
      if (ref_req_o) begin
        if (exp_idx >= NCH) begin
          chk("extra_req", int'(ref_req_o), 0);
        end else begin
          chk("ref_idx", int'(ref_idx_o), exp_idx);
          if (req_cnt > 0) chk("wr_in_stall", int'(pwm_wr_o), 0);
          if (req_cnt >= dly[exp_idx]) begin
            ref_valid_i = 1'b1;
            ref_data_i  = W'(refs[exp_idx]);
            req_cnt     = 0;
            exp_idx++;
          end else begin
            req_cnt++;
            ref_data_i = W'($urandom);
          end
        end
      end else begin
        // valid outside REQ must be ignored
        ref_valid_i = 1'($urandom_range(0, 1));
        ref_data_i  = W'($urandom);
      end
      prev_wr = pwm_wr_o;
    end
    chk("step_done_seen", int'(done), 1);
    for (int k = 0; k < NCH; k++) chk($sformatf("pwm_bit_ch%0d", k), got[k], exp_b[k]);
  endtask

  task automatic idle_check(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      chk("idle_busy", int'(busy_o), 0);
      chk("idle_req", int'(ref_req_o), 0);
      chk("idle_wr", int'(pwm_wr_o), 0);
      ref_valid_i = 1'($urandom_range(0, 1));
      ref_data_i  = W'($urandom);
    end
  endtask

  initial begin
    //             cb     r0       r1    r2       r3      d0..d3     b0..b3     ca
    tbl[0]  = mk(   0,     50,     -50,     0,       1,  1,1,1,1,  1,0,0,1,   300);
    tbl[1]  = mk( 300,      0,       0,     0,       0,  1,1,5,1,  0,0,0,0,   600);
    tbl[2]  = mk( 600,    601,     600,   599, -131072,  0,2,0,3,  1,0,0,0,   900);
    tbl[3]  = mk( 900, 131071,     900,   901,       0,  1,0,1,0,  1,0,1,0,  1000);
    tbl[4]  = mk(1000,   1000,    1001,   999,   -1000,  1,1,1,1,  0,1,0,0,   700);
    tbl[5]  = mk( 700,    701,     701,   700,    -700,  0,0,0,0,  1,1,0,0,   400);
    tbl[6]  = mk( 400,      0,       0,     0,       0,  1,1,1,1,  0,0,0,0,   100);
    tbl[7]  = mk( 100,      0,       0,     0,       0,  1,1,1,1,  0,0,0,0,  -200);
    tbl[8]  = mk(-200,      0,       0,     0,       0,  1,1,1,1,  1,1,1,1,  -500);
    tbl[9]  = mk(-500,   -499,    -500,  -501,       0,  2,0,1,0,  1,0,0,1,  -800);
    tbl[10] = mk(-800, -131072,   -799,  -800,  131071,  1,1,1,1,  0,1,0,1, -1000);
    tbl[11] = mk(-1000,-131072,  -1000,  -999,   -1001,  0,1,0,1,  0,0,1,0,  -700);
    tbl[12] = mk(-700,      0,       0,     0,       0,  1,1,1,1,  1,1,1,1,  -400);

    repeat (3) @(negedge clk);
    chk("rst_req",     int'(ref_req_o),   0);
    chk("rst_idx",     int'(ref_idx_o),   0);
    chk("rst_bit",     int'(pwm_bit_o),   0);
    chk("rst_wr",      int'(pwm_wr_o),    0);
    chk("rst_done",    int'(step_done_o), 0);
    chk("rst_busy",    int'(busy_o),      0);
    chk("rst_carrier", int'(carrier_o),   0);
    chk("rst_overrun", int'(overrun_o),   0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      exp_pre  = tbl[i].car_before;
      exp_post = tbl[i].car_after;
      for (int k = 0; k < NCH; k++) begin
        refs[k]  = int'($signed(tbl[i].r[k]));
        dly[k]   = int'(tbl[i].d[k]);
        exp_b[k] = int'(tbl[i].b[k]);
      end
      run_step(0);
      model_adv();
    end
    chk("overrun_clean", int'(overrun_o), 0);

    // start while busy mid-sweep
    prepare_random();
    run_step(1);
    chk("overrun_mid", int'(overrun_o), 1);

    // asynchronous reset while channel 1 is being requested
    start_i = 1'b1;
    @(negedge clk);
    start_i     = 1'b0;
    ref_valid_i = 1'b1;
    ref_data_i  = 18'sd100000;
    @(negedge clk);
    ref_valid_i = 1'b0;
    @(negedge clk);
    chk("mid_idx", int'(ref_idx_o), 1);
    chk("mid_wr",  int'(pwm_wr_o),  1);
    chk("mid_bit", int'(pwm_bit_o), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req",     int'(ref_req_o),   0);
    chk("arst_idx",     int'(ref_idx_o),   0);
    chk("arst_bit",     int'(pwm_bit_o),   0);
    chk("arst_wr",      int'(pwm_wr_o),    0);
    chk("arst_done",    int'(step_done_o), 0);
    chk("arst_busy",    int'(busy_o),      0);
    chk("arst_carrier", int'(carrier_o),   0);
    chk("arst_overrun", int'(overrun_o),   0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    car_m = 0;
    dn_m  = 1'b0;
    idle_check(5);

    // start on the carrier-update cycle: overrun, no second sweep
    prepare_random();
    run_step(2);
    chk("overrun_upd", int'(overrun_o), 1);
    idle_check(6);

    for (int s = 0; s < 40; s++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        start_i     = 1'b0;
        ref_valid_i = 1'($urandom_range(0, 1));
        ref_data_i  = W'($urandom);
      end
      prepare_random();
      run_step(0);
    end
    chk("overrun_sticky", int'(overrun_o), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
